// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Fetch stage with program counter, instruction-memory
//               addressing and the IF/ID pipeline register. Applies J/JR and
//               EX branch redirects, load-use stalls and squash bubbles, and
//               counts taken redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   j_id,
    input  logic                   jr_id,
    input  logic [31:0]            jr_target_id,
    input  logic                   branch_taken_ex,
    input  logic [31:0]            branch_target_ex,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]            imem_data,
    output logic [31:0]            pc_if,
    output logic [31:0]            instr_id,
    output logic [31:0]            pc_plus4_id,
    output logic                   valid_id,
    output logic [15:0]            redirect_cnt
);

    localparam logic [31:0] c_nop       = 32'h0000_0000;
    localparam logic [31:0] c_align     = 32'hFFFF_FFFC;
    localparam logic [15:0] c_cnt_max   = 16'hFFFF;
    localparam logic [31:0] c_pc_reset  = RESET_PC & c_align;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;
    logic [15:0] r_redirect_cnt;

    logic [31:0] w_pc_seq;
    logic [31:0] w_j_target;
    logic [31:0] w_next_pc;
    logic        w_hold;
    logic        w_squash;

    assign w_pc_seq   = r_pc + 32'd4;
    assign w_j_target = {r_pc_plus4[31:28], r_instr[25:0], 2'b00};

    // Exactly one action per edge; EX branch outranks stall because the
    // stalled ID instruction is the one being squashed.
    always_comb begin
        w_next_pc = w_pc_seq;
        w_hold    = 1'b0;
        w_squash  = 1'b0;
        if (branch_taken_ex) begin
            w_next_pc = branch_target_ex & c_align;
            w_squash  = 1'b1;
        end else if (stall) begin
            w_next_pc = r_pc;
            w_hold    = 1'b1;
        end else if (jr_id) begin
            w_next_pc = jr_target_id & c_align;
            w_squash  = 1'b1;
        end else if (j_id) begin
            w_next_pc = w_j_target;
            w_squash  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc           <= c_pc_reset;
            r_instr        <= c_nop;
            r_pc_plus4     <= 32'h0000_0000;
            r_valid        <= 1'b0;
            r_redirect_cnt <= 16'h0000;
        end else if (!w_hold) begin
            r_pc <= w_next_pc;
            if (w_squash) begin
                r_instr    <= c_nop;
                r_pc_plus4 <= 32'h0000_0000;
                r_valid    <= 1'b0;
                if (r_redirect_cnt != c_cnt_max) begin
                    r_redirect_cnt <= r_redirect_cnt + 16'd1;
                end
            end else begin
                r_instr    <= imem_data;
                r_pc_plus4 <= w_pc_seq;
                r_valid    <= 1'b1;
            end
        end
    end

    assign imem_addr    = r_pc[IMEM_ADDR_W+1:2];
    assign pc_if        = r_pc;
    assign instr_id     = r_instr;
    assign pc_plus4_id  = r_pc_plus4;
    assign valid_id     = r_valid;
    assign redirect_cnt = r_redirect_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// Directed bench for instruction_fetch: walks reset, fetch, J/JR/branch
// redirects, stalls, PC wrap, counter saturation and async reset.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        j_id;
    logic        jr_id;
    logic [31:0] jr_target_id;
    logic        branch_taken_ex;
    logic [31:0] branch_target_ex;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc_if;
    logic [31:0] instr_id;
    logic [31:0] pc_plus4_id;
    logic        valid_id;
    logic [15:0] redirect_cnt;

    logic [31:0] mem [256];
    int checks;
    int failures;

    instruction_fetch #(
        .RESET_PC    (32'h0000_0000),
        .IMEM_ADDR_W (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .j_id             (j_id),
        .jr_id            (jr_id),
        .jr_target_id     (jr_target_id),
        .branch_taken_ex  (branch_taken_ex),
        .branch_target_ex (branch_target_ex),
        .imem_addr        (imem_addr),
        .imem_data        (imem_data),
        .pc_if            (pc_if),
        .instr_id         (instr_id),
        .pc_plus4_id      (pc_plus4_id),
        .valid_id         (valid_id),
        .redirect_cnt     (redirect_cnt)
    );

    assign imem_data = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; j_id = 0; jr_id = 0; jr_target_id = 0;
        branch_taken_ex = 0; branch_target_ex = 0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | i;
        mem[0] = 32'h2001_0005;
        mem[1] = 32'h2002_0007;
        mem[3] = 32'h0800_0030;   // J to 0xC0
        mem[8] = 32'h0800_0010;   // J to 0x40
        idle_inputs();
        rst_n = 1;

        // Reset values, asserted before any clock edge
        #1 rst_n = 0;
        #1;
        chk("rst_pc", pc_if, 32'h0);
        chk("rst_instr", instr_id, 32'h0);
        chk("rst_pc4", pc_plus4_id, 32'h0);
        chk("rst_valid", {31'b0, valid_id}, 32'h0);
        chk("rst_cnt", {16'b0, redirect_cnt}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;

        // Sequential fetch
        step();
        chk("seq1_pc", pc_if, 32'h4);
        chk("seq1_instr", instr_id, 32'h2001_0005);
        chk("seq1_pc4", pc_plus4_id, 32'h4);
        chk("seq1_valid", {31'b0, valid_id}, 32'h1);
        step();
        chk("seq2_pc", pc_if, 32'h8);
        chk("seq2_instr", instr_id, 32'h2002_0007);
        chk("seq2_pc4", pc_plus4_id, 32'h8);
        step();
        step();
        chk("seq4_pc", pc_if, 32'h10);
        chk("seq4_instr", instr_id, 32'h0800_0030);
        chk("imem_addr_10", {24'b0, imem_addr}, 32'h4);

        // Stall for 3 edges with a pending J in IF/ID
        stall = 1; j_id = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_pc", pc_if, 32'h10);
            chk("stall_instr", instr_id, 32'h0800_0030);
            chk("stall_pc4", pc_plus4_id, 32'h10);
            chk("stall_valid", {31'b0, valid_id}, 32'h1);
            chk("stall_cnt", {16'b0, redirect_cnt}, 32'h0);
        end
        stall = 0;
        step();
        chk("jpend_pc", pc_if, 32'hC0);
        chk("jpend_instr", instr_id, 32'h0);
        chk("jpend_valid", {31'b0, valid_id}, 32'h0);
        chk("jpend_cnt", {16'b0, redirect_cnt}, 32'h1);

        // JR with a misaligned target
        j_id = 0; jr_id = 1; jr_target_id = 32'h23;
        step();
        chk("jr_pc", pc_if, 32'h20);
        chk("jr_valid", {31'b0, valid_id}, 32'h0);
        chk("jr_cnt", {16'b0, redirect_cnt}, 32'h2);
        jr_id = 0;
        step();
        chk("refill_instr", instr_id, 32'h0800_0010);
        chk("refill_pc4", pc_plus4_id, 32'h24);
        chk("refill_valid", {31'b0, valid_id}, 32'h1);

        // J redirect
        j_id = 1;
        step();
        chk("j_pc", pc_if, 32'h40);
        chk("j_instr", instr_id, 32'h0);
        chk("j_valid", {31'b0, valid_id}, 32'h0);
        chk("j_cnt", {16'b0, redirect_cnt}, 32'h3);

        // J and JR together: JR wins
        jr_id = 1; jr_target_id = 32'h200;
        step();
        chk("jrj_pc", pc_if, 32'h200);
        chk("jrj_cnt", {16'b0, redirect_cnt}, 32'h4);

        // Branch beats stall and JR
        branch_taken_ex = 1; branch_target_ex = 32'h103; stall = 1;
        step();
        chk("br_pc", pc_if, 32'h100);
        chk("br_valid", {31'b0, valid_id}, 32'h0);
        chk("br_cnt", {16'b0, redirect_cnt}, 32'h5);
        branch_taken_ex = 0; jr_id = 0; j_id = 0;
        step();
        chk("br_stall_pc", pc_if, 32'h100);
        chk("br_stall_valid", {31'b0, valid_id}, 32'h0);
        chk("br_stall_cnt", {16'b0, redirect_cnt}, 32'h5);
        stall = 0;
        step();
        chk("br_seq_pc", pc_if, 32'h104);
        chk("br_seq_instr", instr_id, 32'h1000_0040);
        chk("br_seq_pc4", pc_plus4_id, 32'h104);

        // PC wrap
        branch_taken_ex = 1; branch_target_ex = 32'hFFFF_FFFC;
        step();
        chk("wrap_pre_pc", pc_if, 32'hFFFF_FFFC);
        chk("wrap_addr", {24'b0, imem_addr}, 32'hFF);
        branch_taken_ex = 0;
        step();
        chk("wrap_pc", pc_if, 32'h0);
        chk("wrap_instr", instr_id, 32'h1000_00FF);
        chk("wrap_pc4", pc_plus4_id, 32'h0);
        chk("wrap_valid", {31'b0, valid_id}, 32'h1);

        // Async reset between edges while a J is presented
        j_id = 1;
        #2 rst_n = 0;
        #1;
        chk("arst_pc", pc_if, 32'h0);
        chk("arst_instr", instr_id, 32'h0);
        chk("arst_valid", {31'b0, valid_id}, 32'h0);
        chk("arst_cnt", {16'b0, redirect_cnt}, 32'h0);
        @(posedge clk);
        #1;
        j_id = 0;
        rst_n = 1;
        step();
        chk("arst_seq_pc", pc_if, 32'h4);
        chk("arst_seq_instr", instr_id, 32'h2001_0005);

        // Counter saturation: 70000 redirects in total
        branch_taken_ex = 1; branch_target_ex = 32'h0;
        repeat (65534) @(posedge clk);
        #1;
        chk("cnt_fffe", {16'b0, redirect_cnt}, 32'hFFFE);
        step();
        chk("cnt_ffff", {16'b0, redirect_cnt}, 32'hFFFF);
        repeat (4465) @(posedge clk);
        #1;
        chk("cnt_sat", {16'b0, redirect_cnt}, 32'hFFFF);
        branch_taken_ex = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage and IF/ID pipeline register of the five-stage pipeline CPU. It holds the program counter, addresses the instruction memory, and latches the fetched word plus PC+4 into the IF/ID register that drives the instruction decoder. It applies the control-flow redirects produced downstream: J and JR resolved in ID, conditional branches resolved in EX. It also applies load-use stalls, inserts NOP bubbles on squash, and counts redirects for performance monitoring.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (low 2 bits must be 0)
- IMEM_ADDR_W, 8, word-address width of instruction memory

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  load-use hazard from ID; hold PC and IF/ID
- j_id  in  1  instruction in IF/ID is J (from decoder)
- jr_id  in  1  instruction in IF/ID is JR (from decoder)
- jr_target_id  in  32  forwarded rs value for JR
- branch_taken_ex  in  1  branch in EX resolved taken
- branch_target_ex  in  32  branch target computed in EX
- imem_addr  out  IMEM_ADDR_W  word address = pc_if[IMEM_ADDR_W+1:2]
- imem_data  in  32  instruction word, combinational read of imem_addr
- pc_if  out  32  current fetch PC
- instr_id  out  32  IF/ID instruction register (to decoder)
- pc_plus4_id  out  32  IF/ID PC+4 register
- valid_id  out  1  IF/ID holds a real instruction (0 = bubble)
- redirect_cnt  out  16  saturating count of taken redirects

## Operation
- Reset: pc_if=RESET_PC, instr_id=32'h0, pc_plus4_id=32'h0, valid_id=0, redirect_cnt=0. All outputs take these values immediately on rst_n low, asynchronously. Reset mid-operation discards any pending redirect.
- NOP encoding is 32'h0000_0000. The decoder treats it as no operation, with no register write.
- Each rising edge takes exactly one action, in strict priority order:
  - 1) branch_taken_ex: pc_if<=branch_target_ex; IF/ID<=NOP, valid_id<=0. This overrides stall, j_id and jr_id, because the ID instruction is squashed.
  - 2) stall: pc_if, instr_id, pc_plus4_id and valid_id hold. j_id/jr_id are ignored this cycle and take effect once stall drops, since IF/ID still holds the jump.
  - 3) jr_id: pc_if<=jr_target_id; IF/ID<=NOP, valid_id<=0.
  - 4) j_id: pc_if<={pc_plus4_id[31:28], instr_id[25:0], 2'b00}; IF/ID<=NOP, valid_id<=0.
  - 5) sequential: pc_if<=pc_if+4; instr_id<=imem_data; pc_plus4_id<=pc_if+4; valid_id<=1.
- j_id and jr_id are mutually exclusive by decode. If both are high, jr_id wins.
- Target alignment: bits [1:0] of every redirect target are forced to 2'b00 before loading pc_if.
- PC arithmetic is 32-bit modular: 32'hFFFF_FFFC+4 = 32'h0000_0000, with no error flag.
- imem_addr takes pc_if bits above bit 1, truncated to IMEM_ADDR_W. Upper PC bits are ignored for addressing.
- redirect_cnt increments by 1 on each edge where action 1, 3 or 4 is taken, and saturates at 16'hFFFF.
- No branch delay slot: the sequentially fetched instruction behind a redirect is always squashed.

## Timing
- Fetch latency: imem_data is sampled on the same edge at which pc_if advances. The instruction at PC appears on instr_id one cycle after pc_if=PC.
- J/JR penalty: 1 bubble. The target PC appears on pc_if in the cycle after the edge where j_id/jr_id is sampled.
- EX branch penalty: 1 bubble in IF/ID. The ID/EX bubble is inserted outside this block.
- Stall has zero latency: state is frozen on the first edge stall is high and resumes on the first edge stall is low.
- All outputs are registered except imem_addr, which is combinational from pc_if.

## Test plan
- Reset and sequential fetch: rst_n low then high with RESET_PC=0 and imem words 0x20010005, 0x20020007 at word addresses 0 and 1. Required: pc_if reads 0, 4, 8 on successive edges; instr_id reads 0x20010005 then 0x20020007; valid_id=1 from the first edge; pc_plus4_id reads 4 then 8.
- J redirect: instr_id=0x08000010 and pc_plus4_id=0x00000024, with j_id=1 for one edge. Required: next pc_if=0x00000040; instr_id=0 and valid_id=0 for one cycle; redirect_cnt increments by 1.
- Branch beats stall and JR: branch_taken_ex=1 with target 0x00000103, while stall=1 and jr_id=1 (jr_target 0x200). Required: pc_if=0x00000100 and valid_id=0. The following cycle, stall holds state.
- Stall holds: stall=1 for 3 edges at pc_if=0x10. Required: pc_if, instr_id, pc_plus4_id and valid_id unchanged. A pending j_id is applied on the first edge after stall drops.
- Wrap and saturation: pc_if=0xFFFFFFFC, sequential step. Required: next pc_if=0x00000000. Forcing 70000 redirects leaves redirect_cnt=0xFFFF.
- Async reset mid-operation: rst_n pulsed low between clock edges during a J redirect. Required: outputs return to reset values immediately, before the next edge, and the jump is not applied.
